// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART blocks (TX frame serialiser, bit timer and
//   the RX side that reuses the timer).
//
//   Contents:
//     PAR_NONE / PAR_EVEN / PAR_ODD   parity_mode encodings (2'b11 is reserved
//                                     and behaves as PAR_NONE)
//     DATA_BITS_MIN / DATA_BITS_MAX   legal range of the DATA_BITS parameter
//     tx_state_e                      transmitter FSM state encoding
//     frame_cfg_t                     per-frame configuration captured at accept
//     parity_enabled()                1 when a parity bit is inserted
//     parity_of()                     parity bit value from mode and data XOR
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 9;

    // IDLE is encoded as zero so that "busy" is simply a non-zero state.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // Parity is resolved to a single bit at accept time, so the data shift
    // register is free to be consumed while the frame goes out.
    typedef struct packed {
        logic par_en;
        logic par_bit;
        logic two_stop;
    } frame_cfg_t;

    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    function automatic logic parity_of(input logic [1:0] mode, input logic data_xor);
        return (mode == PAR_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
//   Counts clock cycles within one serial bit. bit_tick is a registered flag
//   that is high on the last cycle of every bit; a bit lasts
//   max(cycles_per_bit, 1) cycles, so 0 behaves exactly like 1.
//
//   Ports:
//     clk            clock
//     resetn         asynchronous active-low reset
//     clear          restart the bit: the next cycle is cycle 0 of a new bit
//                    (takes priority over enable)
//     enable         count; when low the timer parks at 0 with no tick
//     cycles_per_bit bit length in cycles; must be stable while counting,
//                    except in the cycle clear is asserted, when it is the
//                    length of the bit being started
//     bit_tick       high during the last cycle of the current bit
//     bit_tick_nxt   value bit_tick takes after the next edge; lets a client
//                    register outputs that must line up with bit_tick
// -----------------------------------------------------------------------------
module uart_bit_timer #(
    parameter int CPB_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [CPB_WIDTH-1:0] cycles_per_bit,
    output logic                 bit_tick,
    output logic                 bit_tick_nxt
);

    logic [CPB_WIDTH-1:0] cnt;
    logic [CPB_WIDTH-1:0] cnt_nxt;
    logic [CPB_WIDTH-1:0] last;

    // Index of the final cycle of a bit; 0 and 1 both give a one-cycle bit.
    assign last = (cycles_per_bit == '0) ? '0 : cycles_per_bit - CPB_WIDTH'(1);

    always_comb begin
        cnt_nxt      = '0;
        bit_tick_nxt = 1'b0;
        if (clear) begin
            cnt_nxt      = '0;
            bit_tick_nxt = (last == '0);
        end else if (enable) begin
            if (bit_tick) begin
                cnt_nxt      = '0;
                bit_tick_nxt = (last == '0);
            end else begin
                cnt_nxt      = cnt + CPB_WIDTH'(1);
                bit_tick_nxt = (cnt_nxt == last);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt      <= '0;
            bit_tick <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            bit_tick <= bit_tick_nxt;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
//   UART transmitter. One word per frame: start bit, DATA_BITS data bits LSB
//   first, optional parity bit, one or two stop bits. Word and frame format
//   are captured on acceptance, so the inputs may change freely during a
//   frame. A new word can be accepted in the final cycle of the last stop bit,
//   which chains frames with no idle gap.
//
//   Parameters:
//     DATA_BITS  data bits per frame, 5..9
//     CPB_WIDTH  width of cycles_per_bit
//
//   Ports:
//     clk            clock
//     resetn         asynchronous active-low reset; abandons any frame
//     cycles_per_bit cycles per serial bit, 0 treated as 1
//     parity_mode    00 none, 01 even, 10 odd, 11 none
//     two_stop       1 = two stop bits
//     tx_data        word to send
//     tx_valid       tx_data valid; accepted when tx_valid & tx_ready
//     tx_ready       high in IDLE and in the final cycle of the last stop bit
//     tx_busy        frame in progress
//     tx_done        one-cycle pulse in the final cycle of each frame
//     tx_line        serial output, idle high, registered
// -----------------------------------------------------------------------------
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int CPB_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [CPB_WIDTH-1:0] cycles_per_bit,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx_line
);

    // DATA_BITS outside DATA_BITS_MIN..DATA_BITS_MAX is not supported; the
    // shift register reads bit 1, so at least two data bits are assumed.
    localparam int                   IDX_W    = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(DATA_BITS - 1);

    tx_state_e            state;
    logic [DATA_BITS-1:0] shreg;      // remaining data, current bit at [0]
    logic [CPB_WIDTH-1:0] cpb_sh;
    frame_cfg_t           cfg_sh;
    logic [IDX_W-1:0]     idx;        // data bit index
    logic                 stop_idx;   // stop bit index

    logic                 accept;
    logic [CPB_WIDTH-1:0] timer_cpb;
    logic                 bit_tick;
    logic                 tick_nxt;

    logic                 final_now;
    logic                 enter_final;
    logic                 final_nxt;
    logic                 idle_nxt;
    logic                 done_nxt;

    assign accept  = tx_valid & tx_ready;
    assign tx_busy = (state != IDLE);

    // The timer sees the incoming rate in the accept cycle so the start bit
    // already has the new frame's length; afterwards it runs off the shadow.
    assign timer_cpb = accept ? cycles_per_bit : cpb_sh;

    uart_bit_timer #(
        .CPB_WIDTH (CPB_WIDTH)
    ) u_bit_timer (
        .clk            (clk),
        .resetn         (resetn),
        .clear          (accept),
        .enable         (tx_busy),
        .cycles_per_bit (timer_cpb),
        .bit_tick       (bit_tick),
        .bit_tick_nxt   (tick_nxt)
    );

    // Look one cycle ahead so tx_ready and tx_done can be flops that are high
    // exactly in the final cycle of the last stop bit.
    always_comb begin
        final_now   = (state == STOP) && (stop_idx == cfg_sh.two_stop);
        enter_final = 1'b0;
        if (bit_tick) begin
            case (state)
                DATA:    enter_final = (idx == IDX_LAST) && !cfg_sh.par_en && !cfg_sh.two_stop;
                PARITY:  enter_final = !cfg_sh.two_stop;
                STOP:    enter_final = cfg_sh.two_stop && !stop_idx;
                default: enter_final = 1'b0;
            endcase
        end
        final_nxt = enter_final || (final_now && !bit_tick);
        done_nxt  = final_nxt && tick_nxt;
        idle_nxt  = !accept && ((state == IDLE) || (final_now && bit_tick));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            shreg    <= '0;
            cpb_sh   <= '0;
            cfg_sh   <= '0;
            idx      <= '0;
            stop_idx <= 1'b0;
            tx_line  <= 1'b1;
            tx_ready <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            tx_done  <= done_nxt;
            tx_ready <= idle_nxt || done_nxt;

            if (accept) begin
                shreg           <= tx_data;
                cpb_sh          <= cycles_per_bit;
                cfg_sh.par_en   <= parity_enabled(parity_mode);
                cfg_sh.par_bit  <= parity_of(parity_mode, ^tx_data);
                cfg_sh.two_stop <= two_stop;
                state           <= START;
                idx             <= '0;
                stop_idx        <= 1'b0;
                tx_line         <= 1'b0;
            end else if (bit_tick) begin
                case (state)
                    START: begin
                        state   <= DATA;
                        idx     <= '0;
                        tx_line <= shreg[0];
                    end
                    DATA: begin
                        if (idx == IDX_LAST) begin
                            if (cfg_sh.par_en) begin
                                state   <= PARITY;
                                tx_line <= cfg_sh.par_bit;
                            end else begin
                                state    <= STOP;
                                stop_idx <= 1'b0;
                                tx_line  <= 1'b1;
                            end
                        end else begin
                            idx     <= idx + IDX_W'(1);
                            shreg   <= shreg >> 1;
                            tx_line <= shreg[1];
                        end
                    end
                    PARITY: begin
                        state    <= STOP;
                        stop_idx <= 1'b0;
                        tx_line  <= 1'b1;
                    end
                    STOP: begin
                        tx_line <= 1'b1;
                        if (cfg_sh.two_stop && !stop_idx) begin
                            stop_idx <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        // IDLE: a stale tick left over from the last frame
                        state   <= IDLE;
                        tx_line <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
